// File: rtl/row_pattern_feeder.sv
// Obstacle-row generator: on each roll_clock rise emits an LFSR row, pulses load_n
// for the external shift register, then tracks the 12 serial shift cycles MSB first.
module row_pattern_feeder #(
  parameter int               WIDTH = 12,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(12'hA5C)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             roll_clock,
  input  logic             run,
  output logic [WIDTH-1:0] pattern,
  output logic             load_n,
  output logic             bit_valid,
  output logic             ser_out,
  output logic             row_done,
  output logic             busy,
  output logic [7:0]       row_count,
  output logic             overrun
);

  localparam int BW = $clog2(WIDTH);
  // An all-zero LFSR never leaves zero, so a zero seed is replaced.
  localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;
  localparam logic [WIDTH-1:0] GAP_ROW  = {{(WIDTH-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t           state_q;
  logic             s1_q, s2_q, s3_q;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] pattern_q, row_d;
  logic [WIDTH-1:0] sh_q;
  logic [BW-1:0]    idx_q;
  logic [7:0]       cnt_q, cnt_d;
  logic             load_n_q, bit_valid_q, ser_q, row_done_q, busy_q, ovr_q;
  logic             rise, fb;

  always_comb begin
    rise   = s2_q & ~s3_q;
    fb     = lfsr_q[WIDTH-1] ^ lfsr_q[5] ^ lfsr_q[3] ^ lfsr_q[0];
    lfsr_d = (lfsr_q == '0) ? SEED_EFF : {lfsr_q[WIDTH-2:0], fb};
    // Solid rows would be impassable; keep the rightmost column open.
    row_d  = (lfsr_q == '1) ? GAP_ROW : lfsr_q;
    cnt_d  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      lfsr_q      <= SEED_EFF;
      pattern_q   <= '0;
      sh_q        <= '0;
      idx_q       <= '0;
      cnt_q       <= 8'd0;
      load_n_q    <= 1'b1;
      bit_valid_q <= 1'b0;
      ser_q       <= 1'b0;
      row_done_q  <= 1'b0;
      busy_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      s1_q <= roll_clock;
      s2_q <= s1_q;
      s3_q <= s2_q;
      // A rise while a row is in flight is dropped, never queued.
      if (rise && state_q != IDLE) ovr_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (rise && run) begin
            state_q   <= LOAD;
            pattern_q <= row_d;
            lfsr_q    <= lfsr_d;
            cnt_q     <= cnt_d;
            load_n_q  <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        LOAD: begin
          state_q     <= SHIFT;
          load_n_q    <= 1'b1;
          bit_valid_q <= 1'b1;
          ser_q       <= pattern_q[WIDTH-1];
          sh_q        <= pattern_q << 1;
          idx_q       <= '0;
          row_done_q  <= (WIDTH == 1);
        end
        SHIFT: begin
          if (idx_q == BW'(WIDTH-1)) begin
            state_q     <= IDLE;
            bit_valid_q <= 1'b0;
            ser_q       <= 1'b0;
            row_done_q  <= 1'b0;
            busy_q      <= 1'b0;
          end else begin
            idx_q      <= idx_q + 1'b1;
            ser_q      <= sh_q[WIDTH-1];
            sh_q       <= sh_q << 1;
            row_done_q <= (idx_q == BW'(WIDTH-2));
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pattern   = pattern_q;
  assign load_n    = load_n_q;
  assign bit_valid = bit_valid_q;
  assign ser_out   = ser_q;
  assign row_done  = row_done_q;
  assign busy      = busy_q;
  assign row_count = cnt_q;
  assign overrun   = ovr_q;

endmodule

// File: doc/row_pattern_feeder.md
Name: row_pattern_feeder

Overview:
Generates the obstacle rows for the scrolling play field and feeds the 12-bit parallel-load shift register. On each rising edge of the slow roll clock it produces a new pseudo-random 12-bit row from an LFSR and pulses the register's active-low load. It then lets the register shift the row out serially, MSB first, over the next 12 cycles. It also counts emitted rows and flags roll ticks that arrive while a row is still being shifted.

Parameters:
WIDTH, 12, row width in bits; equals the shift register width.
SEED, 12'hA5C, LFSR value after reset; 0 is illegal and is replaced by 12'h001.

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
roll_clock  input  1  slow roll clock (square wave, asynchronous to clock)
run  input  1  1 = emit rows on roll edges; 0 = hold in idle
pattern  output  WIDTH  row value for shift register d; held stable from LOAD until next LOAD
load_n  output  1  drives shift register enable; 0 = parallel load, 1 = shift
bit_valid  output  1  high during the 12 shift cycles
ser_out  output  1  expected serial bit, pattern[WIDTH-1-bit_idx]; 0 when bit_valid=0
row_done  output  1  one-cycle pulse on the last shift cycle
busy  output  1  state != IDLE
row_count  output  8  rows emitted, saturating
overrun  output  1  sticky; roll edge arrived while busy

Behaviour:
- Reset values, applied at the clock edge while reset=1:
  - state=IDLE, lfsr=SEED, pattern=0, load_n=1, bit_valid=0, ser_out=0
  - row_done=0, busy=0, row_count=0, overrun=0
  - sync flops s1, s2, s3 = 0
- Reset mid-row aborts the row; no partial completion.
- Edge detect:
  - roll_clock passes through s1 then s2; s3 holds the previous s2.
  - rise = s2 & ~s3.
  - If roll_clock is first sampled high at edge N, rise is true between edges N+1 and N+2.
- FSM states: IDLE, LOAD, SHIFT.
- IDLE:
  - If rise and run, go to LOAD at the next edge (edge N+2).
  - If rise and not run, ignore it; it is not counted as overrun.
- LOAD (exactly 1 cycle):
  - load_n=0 and pattern=row(lfsr).
  - lfsr advances one step.
  - row_count increments, saturating at 255.
  - Go to SHIFT next edge.
- SHIFT (exactly WIDTH cycles, bit_idx 0..WIDTH-1):
  - load_n=1, bit_valid=1, ser_out=pattern[WIDTH-1-bit_idx].
  - row_done=1 when bit_idx=WIDTH-1.
  - After the last cycle, go to IDLE.
- Total busy time is 1+WIDTH = 13 cycles per row.
- LFSR step: fb = lfsr[11]^lfsr[5]^lfsr[3]^lfsr[0]; lfsr_next = {lfsr[10:0], fb}.
- If lfsr is ever 0, the next value is SEED (lock-up escape).
- row(v) gap guarantee: if v == 12'hFFF, pattern = 12'hFFE (one passable column); otherwise pattern = v.
- Overrun:
  - A rise while busy (LOAD or SHIFT) sets overrun=1. That edge is dropped and never queued.
  - overrun clears only on reset.
- run deasserted mid-row: the current row completes normally; no new LOAD follows.
- Simultaneous rise and row_done: treated as overrun (state is still SHIFT); the FSM returns to IDLE.
- Outputs load_n, bit_valid, ser_out, row_done and busy are registered from state; none is combinational from inputs.

Test Plan:
1. Reset, run=1, raise roll_clock at edge N -> load_n=0 for exactly one cycle starting edge N+2, pattern=12'hA5C, row_count=1. Next roll edge gives pattern=12'h4B8.
2. Row 1 serial check -> bit_valid high for 12 cycles from edge N+3. ser_out sequence is 1,0,1,0,0,1,0,1,1,1,0,0. Attached shift register q matches ser_out each cycle. row_done pulses only on the 12th cycle.
3. Second roll rising edge 5 cycles after the first LOAD -> overrun=1; no second LOAD; row_count stays 1; overrun stays 1 until reset.
4. run=0 at a roll edge -> no LOAD, busy=0. run dropped mid-SHIFT -> row completes all 12 bits, then IDLE; the next roll edge is ignored.
5. Force lfsr to 12'hFFF via SEED=12'hFFF -> pattern=12'hFFE. SEED=0 -> first pattern=12'h001.
6. Assert reset during SHIFT bit_idx=6 -> next edge all outputs are at reset values and lfsr=SEED. 300 roll edges -> row_count saturates at 255.
